comm_slave_frame: RTL

//  Responder end of the 3-byte command link. Reassembles cmd, data[15:8] and data[7:0]

---
 rtl/comm_slave_frame.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/comm_slave_frame.sv
// Responder end of the 3-byte command link: reassembles {cmd, data_hi, data_lo} from UART
// bytes into one command word and sends single-byte responses back through the UART TX.
module comm_slave_frame #(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned TO_W        = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        snd_resp,
  output logic [7:0]  tx_byte,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam logic [TO_W-1:0] TimeoutMax = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StDhi, StDlo} rx_state_e;
  typedef enum logic {StTxIdle, StTxBusy} tx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [7:0]      shadow_cmd_q, shadow_cmd_d;
  logic [7:0]      shadow_hi_q, shadow_hi_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [15:0]     data_q, data_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            frm_err_q, frm_err_d;

  tx_state_e       tx_state_q, tx_state_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            trmt_q, trmt_d;
  logic            resp_sent_q, resp_sent_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    timer_d      = timer_q;
    shadow_cmd_d = shadow_cmd_q;
    shadow_hi_d  = shadow_hi_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    // The consumer's clear takes effect before any same-cycle commit.
    cmd_rdy_d    = cmd_rdy_q & ~clr_cmd_rdy;
    frm_err_d    = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        timer_d = '0;
        if (rx_rdy) begin
          shadow_cmd_d = rx_byte;
          rx_state_d   = StDhi;
        end
      end
      StDhi, StDlo: begin
        if (rx_rdy) begin
          timer_d = '0;
          if (rx_state_q == StDhi) begin
            shadow_hi_d = rx_byte;
            rx_state_d  = StDlo;
          end else begin
            rx_state_d = StIdle;
            if (cmd_rdy_q && !clr_cmd_rdy) begin
              frm_err_d = 1'b1;
            end else begin
              cmd_d     = shadow_cmd_q;
              data_d    = {shadow_hi_q, rx_byte};
              cmd_rdy_d = 1'b1;
            end
          end
        end else if (timer_q == TimeoutMax) begin
          rx_state_d   = StIdle;
          timer_d      = '0;
          shadow_cmd_d = '0;
          shadow_hi_d  = '0;
          frm_err_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_byte_d   = tx_byte_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    unique case (tx_state_q)
      StTxIdle: begin
        if (snd_resp) begin
          tx_byte_d  = resp;
          trmt_d     = 1'b1;
          tx_state_d = StTxBusy;
        end
      end
      StTxBusy: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = StTxIdle;
        end
      end
      default: tx_state_d = StTxIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= StIdle;
      timer_q      <= '0;
      shadow_cmd_q <= '0;
      shadow_hi_q  <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      cmd_rdy_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      tx_state_q   <= StTxIdle;
      tx_byte_q    <= '0;
      trmt_q       <= 1'b0;
      resp_sent_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      timer_q      <= timer_d;
      shadow_cmd_q <= shadow_cmd_d;
      shadow_hi_q  <= shadow_hi_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      cmd_rdy_q    <= cmd_rdy_d;
      frm_err_q    <= frm_err_d;
      tx_state_q   <= tx_state_d;
      tx_byte_q    <= tx_byte_d;
      trmt_q       <= trmt_d;
      resp_sent_q  <= resp_sent_d;
    end
  end

  assign cmd       = cmd_q;
  assign data      = data_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frm_err   = frm_err_q;
  assign tx_byte   = tx_byte_q;
  assign trmt      = trmt_q;
  assign resp_sent = resp_sent_q;

endmodule
